exec_unit: RTL
==============

# exec_unit

Execute stage of the 16-bit CPU, sitting directly downstream of the 8-entry register file. It captures the two register-file read operands, performs one ALU operation (single-cycle logic/arithmetic/shift, or multi-cycle shift-add multiply), and drives the register file's write port (`c_index`, `d_input`, `we`) with a one-cycle write-back pulse. It also provides registered zero and carry flags to the control logic.

## Interface
- `WIDTH`, 16: data width; matches the register file bus.
- `IDX_W`, 3: register index width; 8 registers.
- `clk` in 1: single clock, all state on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: issue request; sampled only when `busy`=0.
- `op` in 3: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL.
- `dst` in IDX_W: destination register index.
- `a_in` in WIDTH: operand A, from register file `a_output`.
- `b_in` in WIDTH: operand B, from register file `b_output`.
- `busy` out 1: high whenever the state is not IDLE.
- `we` out 1: write-enable pulse to the register file.
- `c_index` out IDX_W: write index to the register file.
- `d_out` out WIDTH: write data to the register file `d_input`.
- `flag_z` out 1: result == 0, from the last write-back.
- `flag_c` out 1: carry/borrow/shift-out/overflow, from the last write-back.

## Operation
- FSM states: IDLE, EXEC, WB.
  - IDLE + `start`: latch `op`, `dst`, `a_in`, `b_in`.
    - MUL goes to EXEC.
    - All other ops: compute the result on the same edge and go to WB.
  - EXEC: one shift-add iteration per cycle, tracked by a 4-bit counter 0..15.
    - The multiplier LSB is examined each cycle; the multiplicand shifts left.
    - After iteration 15, go to WB.
  - WB: `we`=1 for exactly this cycle; flags update at the end of this cycle; go to IDLE.
- `start` in EXEC or WB is ignored. Operands and op are not re-latched.
- Arithmetic, all modulo 2^16:
  - ADD: C = carry out of bit 15.
  - SUB: a−b; C = borrow (a<b unsigned).
  - AND, OR, XOR: C=0.
  - SHL and SHR: shift amount = `b_in[3:0]`; C = last bit shifted out; C=0 when the amount is 0.
  - MUL: `d_out` = low 16 bits of the 32-bit product; C = 1 if the high 16 bits are nonzero.
- Z = (`d_out` == 0) for every op.
- `d_out`, `c_index`, `flag_z` and `flag_c` hold their values outside WB until the next write-back.
- No bypass is needed. The register file writes at the edge ending WB, and the earliest next `start` is sampled one edge later in IDLE, so it sees the new value.
- Reset (`rst_n`=0, asynchronous, including mid-EXEC or mid-WB):
  - state → IDLE; counter → 0.
  - `busy`=0, `we`=0, `c_index`=0, `d_out`=0x0000, `flag_z`=0, `flag_c`=0.
  - The in-flight op is discarded with no write.

## Timing
- `start` is sampled at edge E0.
- Non-MUL:
  - WB during cycle E0→E1: `we`=1, `busy`=1.
  - Register file written at E1; `busy`=0 after E1.
  - Throughput: 1 op per 2 cycles.
- MUL:
  - EXEC spans E0→E16 (16 cycles); WB spans E16→E17 with `we`=1.
  - Register file written at E17. Latency is 17 cycles from start to write.
- `busy` rises combinationally from state right after E0. `we` is a direct decode of state WB, with no glitch path from inputs.
- Operands must be stable in the cycle `start` is high. They are don't-care afterwards.

## Configuration
- `EXEC_MUL_EN` defined: op 111 is the 16-iteration MUL described above.
- `EXEC_MUL_EN` undefined:
  - No multiplier datapath and no EXEC state.
  - Op 111 becomes MOV: `d_out`=`b_in`, C=0, single-cycle (IDLE → WB).

## Test plan
- ADD: `a_in`=0xFFFF, `b_in`=0x0001, `dst`=3.
  - Required: `we` high for exactly 1 cycle after the `start` edge, `c_index`=3, `d_out`=0x0000, Z=1, C=1, `busy` high for 1 cycle.
- SUB: 0x0003−0x0005 → `d_out`=0xFFFE, C=1, Z=0.
  - Back-to-back: second op AND 0xF0F0&0x0FF0 → 0x00F0, C=0.
  - Required: the second `start` is accepted in the first IDLE cycle after WB.
- Shifts:
  - SHL 0x8001 by `b_in`=0x0001 → 0x0002, C=1.
  - SHR 0x8001 by `b_in`=0x0010 (amount 0) → 0x8001, C=0.
- MUL (macro on): 0x0007×0x0009 → 0x003F, C=0.
  - Required: `we` asserted exactly 17 cycles after the `start` edge.
  - 0x0100×0x0100 → 0x0000, Z=1, C=1.
  - Macro off: op 111 with `b_in`=0x1234 → 0x1234 with 1-cycle latency.
- `start` held high with changing op/`dst` throughout a MUL.
  - Required: exactly one `we` pulse, carrying the originally latched `dst` and result.
  - A new op is accepted only after WB.
- `rst_n` pulled low in EXEC iteration 8.
  - Required: `busy`, `we`, `d_out` and flags go to 0 immediately, and no write occurs.
  - After release, ADD 0x0002+0x0003 → 0x0005, Z=0, C=0.

Source files
------------

// File: rtl/exec_unit.sv
// Execute stage: latches register-file operands, runs one ALU op and issues a one-cycle write-back.
// Define EXEC_MUL_EN for the 16-iteration shift-add MUL on op 111; otherwise op 111 is MOV.
module exec_unit #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [IDX_W-1:0] dst,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             we,
  output logic [IDX_W-1:0] c_index,
  output logic [WIDTH-1:0] d_out,
  output logic             flag_z,
  output logic             flag_c
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WB   = 2'd2;
`ifdef EXEC_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b111;
  localparam logic [1:0] S_EXEC = 2'd1;
`endif

  logic [1:0]       state_reg;
  logic             c_pend_reg;

  logic [WIDTH:0]   alu_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic [SH_W-1:0]  shamt;

  assign shamt = b_in[SH_W-1:0];
  assign busy  = (state_reg != S_IDLE);
  assign we    = (state_reg == S_WB);

  // Single-cycle ALU; the carry rides in bit WIDTH of the extended result.
  always_comb begin
    alu_ext = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_ext = {1'b0, a_in} + {1'b0, b_in};
        alu_res = alu_ext[WIDTH-1:0];
        alu_c   = alu_ext[WIDTH];
      end
      OP_SUB: begin
        alu_ext = {1'b0, a_in} - {1'b0, b_in};
        alu_res = alu_ext[WIDTH-1:0];
        alu_c   = alu_ext[WIDTH];
      end
      OP_AND: alu_res = a_in & b_in;
      OP_OR:  alu_res = a_in | b_in;
      OP_XOR: alu_res = a_in ^ b_in;
      OP_SHL: begin
        alu_ext = {1'b0, a_in} << shamt;
        alu_res = alu_ext[WIDTH-1:0];
        alu_c   = alu_ext[WIDTH];
      end
      OP_SHR: begin
        // Extra LSB catches the last bit shifted out; stays 0 for a zero shift.
        alu_ext = {a_in, 1'b0} >> shamt;
        alu_res = alu_ext[WIDTH:1];
        alu_c   = alu_ext[0];
      end
      default: begin
`ifdef EXEC_MUL_EN
        alu_res = '0;
`else
        alu_res = b_in;
`endif
      end
    endcase
  end

`ifdef EXEC_MUL_EN
  logic [2*WIDTH-1:0] mcand_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0]   mplier_reg;
  logic [3:0]         cnt_reg;
  logic [IDX_W-1:0]   dst_reg;

  assign acc_sum = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_reg  <= '0;
      acc_reg    <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
      dst_reg    <= '0;
    end else if (state_reg == S_IDLE && start && op == OP_MUL) begin
      mcand_reg  <= {{WIDTH{1'b0}}, a_in};
      acc_reg    <= '0;
      mplier_reg <= b_in;
      cnt_reg    <= '0;
      dst_reg    <= dst;
    end else if (state_reg == S_EXEC) begin
      acc_reg    <= acc_sum;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg + 4'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      c_pend_reg <= 1'b0;
      c_index    <= '0;
      d_out      <= '0;
      flag_z     <= 1'b0;
      flag_c     <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
`ifdef EXEC_MUL_EN
            if (op == OP_MUL) begin
              state_reg <= S_EXEC;
            end else
`endif
            begin
              c_index    <= dst;
              d_out      <= alu_res;
              c_pend_reg <= alu_c;
              state_reg  <= S_WB;
            end
          end
        end
`ifdef EXEC_MUL_EN
        S_EXEC: begin
          if (cnt_reg == 4'd15) begin
            c_index    <= dst_reg;
            d_out      <= acc_sum[WIDTH-1:0];
            c_pend_reg <= |acc_sum[2*WIDTH-1:WIDTH];
            state_reg  <= S_WB;
          end
        end
`endif
        S_WB: begin
          // Flags follow the value being written, committed as WB ends.
          flag_z    <= (d_out == '0);
          flag_c    <= c_pend_reg;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule
